// File: rtl/servisia_wb_mem_adapter.sv
// Bridges a 32-bit Wishbone word access onto a byte-wide memory, one byte per cycle.
// Optional `WRITE_SKIP_EN: writes skip byte slots whose select bit is clear.
module servisia_wb_mem_adapter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [19:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_rdt_o,
  output logic        wb_ack_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [19:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i
);

  // BYTEk encodes as k+1 so the next byte slot is a plain increment.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    BYTE2 = 3'd3,
    BYTE3 = 3'd4,
    ACK   = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [17:0] adr_q;
  logic        we_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [23:0] rdt_q;
  logic        in_byte;
  logic [1:0]  idx;
  logic        adr_unused;

  assign adr_unused = ^wb_adr_i[1:0];
  assign in_byte    = state inside {BYTE0, BYTE1, BYTE2, BYTE3};
  assign idx        = 2'(state - BYTE0);

`ifdef WRITE_SKIP_EN
  // First selected byte slot at or above 'from', else straight to ACK.
  function automatic state_t first_sel(input logic [3:0] sel, input int from);
    state_t s;
    s = ACK;
    for (int j = 3; j >= 0; j--)
      if (j >= from && sel[j]) s = state_t'(3'(j + 1));
    return s;
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wb_cyc_i) begin
`ifdef WRITE_SKIP_EN
          state_nxt = wb_we_i ? first_sel(wb_sel_i, 0) : BYTE0;
`else
          state_nxt = BYTE0;
`endif
        end
      end
      BYTE0, BYTE1, BYTE2, BYTE3: begin
`ifdef WRITE_SKIP_EN
        state_nxt = we_q ? first_sel(sel_q, int'(idx) + 1) : state_t'(state + 3'd1);
`else
        state_nxt = state_t'(state + 3'd1);
`endif
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      adr_q <= '0;
      we_q  <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
      rdt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && wb_cyc_i) begin
        adr_q <= wb_adr_i[19:2];
        we_q  <= wb_we_i;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
      end
      // Memory read data lags its address by one cycle.
      case (state)
        BYTE1:   rdt_q[7:0]   <= mem_rdata_i;
        BYTE2:   rdt_q[15:8]  <= mem_rdata_i;
        BYTE3:   rdt_q[23:16] <= mem_rdata_i;
        default: ;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, even before the reset edge.
  always_comb begin
    wb_rdt_o    = '0;
    wb_ack_o    = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rst_ni) begin
      if (in_byte) begin
        mem_addr_o = {adr_q, idx};
        if (!we_q) begin
          mem_read_o = 1'b1;
        end else if (sel_q[idx]) begin
          mem_write_o = 1'b1;
          mem_wdata_o = dat_q[{idx, 3'b000} +: 8];
        end
      end
      if (state == ACK) begin
        wb_ack_o = 1'b1;
        if (!we_q) wb_rdt_o = {mem_rdata_i, rdt_q};
      end
    end
  end

endmodule
